// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory responder: FSM states, typeData and RW
// encodings, wait-state limit, storage geometry and a lane-select helper.
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic TD_BYTE  = 1'b0;
  localparam logic TD_WORD  = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int WAIT_MAX = 15;

  // Storage is four byte-wide banks; a row holds one aligned 32-bit word.
  localparam int ROW_W = 6;

  // One-hot write enable for the bank holding a single byte.
  function automatic logic [3:0] lane_onehot(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/mem_responder_byte_store.sv
// byte_store: 256x8 byte storage organised as four banks, one per byte lane.
// Lane j holds the bytes whose address has [1:0]==j, so an aligned word is one
// row across all four lanes. Writes are synchronous per lane; reads are
// registered. Contents are never reset.
module byte_store
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic [ROW_W-1:0] row,
  input  logic [3:0]       wr_en,
  input  logic [3:0][7:0]  wr_data,
  output logic [3:0][7:0]  rd_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] rd_q;

    // Per-lane synchronous write and registered read of the addressed row
    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        bank[row] <= wr_data[gi];
      end
      rd_q <= bank[row];
    end

    assign rd_data[gi] = rd_q;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: MOV/MOC handshake memory responder with a programmable number
// of wait states. Requests are latched in IDLE, counted down in BUSY and
// acknowledged in DONE until the initiator drops MOV. Word accesses are
// big-endian on the aligned word.
// Optional feature: define MEM_MISALIGN_ERR_EN to add the ERR output, which
// flags misaligned word requests instead of silently aligning them.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int MEM_BYTES   = 256
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic        typeData,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
`ifdef MEM_MISALIGN_ERR_EN
  ,
  output logic        ERR
`endif
);

  localparam logic [3:0] WAIT_LOAD =
    (WAIT_STATES > WAIT_MAX) ? 4'(WAIT_MAX) : 4'(WAIT_STATES);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic [7:0]       addr_reg;
  logic             rw_reg;
  logic             td_reg;
  logic [31:0]      wdata_reg;
  logic             misalign_reg;
  logic             misalign_in;
  logic [31:0]      data_out_reg;
  logic             perform;
  logic [3:0]       wr_en;
  logic [3:0][7:0]  wr_data;
  logic [3:0][7:0]  rd_data;
  logic [ROW_W-1:0] row;
  logic [31:0]      rd_result;

`ifdef MEM_MISALIGN_ERR_EN
  assign misalign_in = (typeData == TD_WORD) && (Address[1:0] != 2'b00);
`else
  assign misalign_in = 1'b0;
`endif

  // State register with synchronous active-low clear
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; dropping MOV in BUSY aborts, in DONE it releases
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (MOV) state_next = ST_BUSY;
      ST_BUSY: begin
        if (!MOV) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: if (!MOV) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: MOC mirrors DONE; the access is performed on the last BUSY edge
  always_comb begin
    MOC     = (state_reg == ST_DONE);
    perform = (state_reg == ST_BUSY) && MOV && (cnt_reg == 4'd0) && CLR;
    wr_en   = 4'h0;
    if (perform && (rw_reg == RW_WRITE) && !misalign_reg) begin
      wr_en = (td_reg == TD_BYTE) ? lane_onehot(addr_reg[1:0]) : 4'hF;
    end
`ifdef MEM_MISALIGN_ERR_EN
    ERR = MOC && misalign_reg;
`endif
  end

  // Request latch, wait counter and read-data register
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      cnt_reg      <= 4'd0;
      addr_reg     <= 8'h00;
      rw_reg       <= 1'b0;
      td_reg       <= 1'b0;
      wdata_reg    <= 32'h0;
      misalign_reg <= 1'b0;
      data_out_reg <= 32'h0;
    end else begin
      if ((state_reg == ST_IDLE) && MOV) begin
        addr_reg     <= Address;
        rw_reg       <= RW;
        td_reg       <= typeData;
        wdata_reg    <= DataIn;
        misalign_reg <= misalign_in;
        cnt_reg      <= WAIT_LOAD;
      end else if ((state_reg == ST_BUSY) && MOV && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (perform) begin
        if (misalign_reg) begin
          data_out_reg <= 32'hFFFF_FFFF;
        end else if (rw_reg == RW_READ) begin
          data_out_reg <= rd_result;
        end
      end
    end
  end

  assign DataOut = data_out_reg;

  // In IDLE the store is read at the incoming address so that the data is
  // already registered when WAIT_STATES is zero; afterwards the latched one.
  assign row = (state_reg == ST_IDLE) ? Address[7:2] : addr_reg[7:2];

  // Lane 0 is the lowest address, which carries the most significant byte
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wr_data[gi] = (td_reg == TD_WORD) ? wdata_reg[31-8*gi -: 8]
                                             : wdata_reg[7:0];
  end

  assign rd_result = (td_reg == TD_WORD)
                   ? {rd_data[0], rd_data[1], rd_data[2], rd_data[3]}
                   : {24'h0, rd_data[addr_reg[1:0]]};

  byte_store #(
    .DEPTH(MEM_BYTES / 4)
  ) u_store (
    .clk    (CLK),
    .row    (row),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard testbench for mem_responder: the driver runs a byte-array
// reference model and queues the expected DataOut per completed access; a
// monitor pops and compares on every MOC rising edge. Handshake timing,
// aborts and reset during DONE are checked by the driver.
module tb_mem_responder;
  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic        typeData = 1'b0;
  logic [7:0]  Address = 8'h00;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        MOC;
`ifdef MEM_MISALIGN_ERR_EN
  logic        ERR;
`endif

  mem_responder #(
    .WAIT_STATES(W),
    .MEM_BYTES  (256)
  ) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .MOV     (MOV),
    .RW      (RW),
    .typeData(typeData),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .MOC     (MOC)
`ifdef MEM_MISALIGN_ERR_EN
    ,
    .ERR     (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_m [256];
  logic [31:0] dout_m = 32'h0;
  int          txn = 0;
  logic        moc_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: flat byte memory, big-endian words on the aligned base
  task automatic model_op(input logic rw, input logic td, input logic [7:0] a,
                          input logic [31:0] d, output exp_t e);
    logic [7:0] b;
    logic       err;
    b   = {a[7:2], 2'b00};
    err = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
    err = td && (a[1:0] != 2'b00);
`endif
    if (err) begin
      dout_m = 32'hFFFF_FFFF;
    end else if (rw) begin
      if (td) dout_m = {mem_m[b], mem_m[b+8'd1], mem_m[b+8'd2], mem_m[b+8'd3]};
      else    dout_m = {24'h0, mem_m[a]};
    end else begin
      if (td) begin
        mem_m[b] = d[31:24]; mem_m[b+8'd1] = d[23:16];
        mem_m[b+8'd2] = d[15:8]; mem_m[b+8'd3] = d[7:0];
      end else begin
        mem_m[a] = d[7:0];
      end
    end
    e.dout = dout_m;
    e.err  = err;
    e.id   = txn;
  endtask

  // Monitor: every MOC rising edge consumes one scoreboard entry
  always @(negedge CLK) begin
    exp_t e;
    if (MOC && !moc_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_moc actual=1 required=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check($sformatf("txn%0d_dataout", e.id), DataOut, e.dout);
`ifdef MEM_MISALIGN_ERR_EN
        check($sformatf("txn%0d_err", e.id), {31'h0, ERR}, {31'h0, e.err});
`endif
      end
    end
    moc_q = MOC;
  end

  // Full handshake; rst_done asserts CLR while in DONE instead of dropping MOV
  task automatic access(input logic rw, input logic td, input logic [7:0] a,
                        input logic [31:0] d, input int hold, input bit rst_done);
    exp_t e;
    int   n;
    txn++;
    model_op(rw, td, a, d, e);
    sb.push_back(e);
    @(posedge CLK); #1;
    MOV = 1'b1; RW = rw; typeData = td; Address = a; DataIn = d;
    @(posedge CLK); #1;
    RW = 1'($urandom); typeData = 1'($urandom);
    Address = 8'($urandom); DataIn = $urandom;
    n = 0;
    @(negedge CLK);
    while (!MOC && n < 40) begin
      n++;
      @(negedge CLK);
    end
    check($sformatf("txn%0d_latency", txn), 32'(n), 32'(W + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check($sformatf("txn%0d_hold_moc", txn), {31'h0, MOC}, 32'h1);
      check($sformatf("txn%0d_hold_data", txn), DataOut, e.dout);
    end
    if (rst_done) begin
      CLR = 1'b0;
      @(posedge CLK); #1;
      CLR = 1'b1; MOV = 1'b0;
      dout_m = 32'h0;
      @(negedge CLK);
      check($sformatf("txn%0d_rst_moc", txn), {31'h0, MOC}, 32'h0);
      check($sformatf("txn%0d_rst_data", txn), DataOut, 32'h0);
    end else begin
      MOV = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("txn%0d_moc_clear", txn), {31'h0, MOC}, 32'h0);
`ifdef MEM_MISALIGN_ERR_EN
      check($sformatf("txn%0d_err_clear", txn), {31'h0, ERR}, 32'h0);
`endif
    end
  endtask

  // Request withdrawn after one BUSY cycle: nothing may change
  task automatic abort_access(input logic rw, input logic td, input logic [7:0] a,
                              input logic [31:0] d);
    txn++;
    @(posedge CLK); #1;
    MOV = 1'b1; RW = rw; typeData = td; Address = a; DataIn = d;
    @(posedge CLK); #1;
    DataIn = $urandom;
    @(posedge CLK); #1;
    MOV = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check($sformatf("txn%0d_abort_moc", txn), {31'h0, MOC}, 32'h0);
    check($sformatf("txn%0d_abort_data", txn), DataOut, dout_m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_moc", {31'h0, MOC}, 32'h0);
    check("reset_data", DataOut, 32'h0);
`ifdef MEM_MISALIGN_ERR_EN
    check("reset_err", {31'h0, ERR}, 32'h0);
`endif
    CLR = 1'b1;

    // Give every location a known value
    for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 8'(i * 4), $urandom, 0, 1'b0);

    // Word write then read back
    access(1'b0, 1'b1, 8'h04, 32'hE201_0000, 0, 1'b0);
    access(1'b1, 1'b1, 8'h04, 32'h0, 2, 1'b0);
    check("word_rd_04_const", DataOut, 32'hE201_0000);
    access(1'b1, 1'b0, 8'h04, 32'h0, 0, 1'b0);
    check("byte_rd_04_const", DataOut, 32'h0000_00E2);
    access(1'b1, 1'b0, 8'h07, 32'h0, 0, 1'b0);
    check("byte_rd_07_const", DataOut, 32'h0000_0000);

    // Byte merge into a word
    access(1'b0, 1'b1, 8'h04, 32'h1122_3344, 1, 1'b0);
    access(1'b0, 1'b0, 8'h05, 32'hFFFF_FFAB, 0, 1'b0);
    access(1'b1, 1'b1, 8'h04, 32'h0, 0, 1'b0);
    check("merge_word_const", DataOut, 32'h11AB_3344);
    access(1'b1, 1'b0, 8'h05, 32'h0, 0, 1'b0);
    check("merge_byte_const", DataOut, 32'h0000_00AB);

    // Aborted write must leave memory and DataOut alone
    abort_access(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b1, 8'h10, 32'h0, 0, 1'b0);

    // Reset while in DONE, then a normal request
    access(1'b1, 1'b1, 8'h20, 32'h0, 1, 1'b1);
    access(1'b0, 1'b1, 8'h20, 32'hCAFE_F00D, 0, 1'b0);
    access(1'b1, 1'b1, 8'h20, 32'h0, 0, 1'b0);
    check("post_reset_word_const", DataOut, 32'hCAFE_F00D);

    // Misaligned word read (error or aligned, depending on build)
    access(1'b1, 1'b1, 8'h06, 32'h0, 1, 1'b0);
`ifdef MEM_MISALIGN_ERR_EN
    check("misalign_data_const", DataOut, 32'hFFFF_FFFF);
`else
    check("misalign_data_const", DataOut, 32'h11AB_3344);
`endif

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        abort_access(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      end else begin
        access(1'($urandom), 1'($urandom), 8'($urandom), $urandom,
               int'($urandom_range(0, 2)), 1'b0);
      end
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
